sw_job_ctrl: RTL and testbench

Job sequencer for the Smith-Waterman systolic PE array. Accepts one alignment job at a time (query length, reference length), preloads query characters into the PE chain, streams reference characters through it, drains the wavefront, and tracks the best local-alignment score and its reference position. It sits between the host-side start/status logic and the PE array plus its query/reference memories.

---
 rtl/sw_job_if.sv | 53 +++++
 rtl/sw_job_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sw_job_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_job_if.sv
// sw_job_if -- bundle between the Smith-Waterman job sequencer and its
// environment (host start/status logic, PE array, query/reference memories).
//
// Optional feature: define SW_ABORT_EN to add the abort request line.
//
// Modports:
//   master : environment side; drives start/lengths/array scores (and abort)
//   slave  : sw_job_ctrl side; drives status, memory and PE array controls
interface sw_job_if #(
  parameter int LEN_W   = 10,
  parameter int SCORE_W = 16
);
  // Host request / status
  logic               start;
  logic [LEN_W-1:0]   q_len;
  logic [LEN_W-1:0]   r_len;
  logic               busy;
  logic               err;
  logic               done;
  logic [SCORE_W-1:0] max_score;
  logic [LEN_W-1:0]   max_pos;
`ifdef SW_ABORT_EN
  logic               abort;
`endif
  // Query / reference memory side
  logic               q_load;
  logic [LEN_W-1:0]   q_addr;
  logic               r_rd;
  logic [LEN_W-1:0]   r_addr;
  // PE array side
  logic               pe_en;
  logic               pe_flush;
  logic               pe_score_vld;
  logic [SCORE_W-1:0] pe_score;

  modport master (
`ifdef SW_ABORT_EN
    output abort,
`endif
    output start, q_len, r_len, pe_score_vld, pe_score,
    input  busy, err, done, max_score, max_pos,
    input  q_load, q_addr, r_rd, r_addr, pe_en, pe_flush
  );

  modport slave (
`ifdef SW_ABORT_EN
    input  abort,
`endif
    input  start, q_len, r_len, pe_score_vld, pe_score,
    output busy, err, done, max_score, max_pos,
    output q_load, q_addr, r_rd, r_addr, pe_en, pe_flush
  );
endinterface

// File: rtl/sw_job_ctrl.sv
// sw_job_ctrl -- job sequencer for the Smith-Waterman systolic PE array.
// One job at a time: preload q_len query characters into the PE chain,
// stream r_len reference characters through it, drain the wavefront for
// q_len+1 cycles, then pulse done. The best score seen on the array output
// and the beat index where it first appeared are tracked throughout the job.
//
// Optional feature: define SW_ABORT_EN to enable the abort input, which
// cancels a running job, flushes the PE array and clears the score tracker.
//
// Ports:
//   clk  : system clock, all state on rising edge
//   rst  : asynchronous active-high reset; every output returns to 0
//   bus  : sw_job_if.slave -- start/q_len/r_len in, busy/err/done status out,
//          q_load/q_addr and r_rd/r_addr memory controls, pe_en/pe_flush
//          array controls, pe_score_vld/pe_score in, max_score/max_pos out
module sw_job_ctrl #(
  parameter int N_PE    = 16,
  parameter int LEN_W   = 10,
  parameter int SCORE_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  sw_job_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_Q, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [LEN_W-1:0] Q_MAX = LEN_W'(N_PE);
  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

  state_t             state, state_n;
  logic [LEN_W-1:0]   cnt, cnt_n;
  logic [LEN_W-1:0]   q_len_r, r_len_r;
  logic [LEN_W-1:0]   q_addr_r, q_addr_n, r_addr_r, r_addr_n;
  logic [LEN_W-1:0]   beat, max_pos_r;
  logic [SCORE_W-1:0] max_score_r;
  logic               busy_r, err_r, q_load_r, r_rd_r, pe_en_r, pe_flush_r, done_r;
  logic               err_n, flush_n, start_ok, abort_hit, legal;

  assign legal = (bus.q_len != '0) && (bus.q_len <= Q_MAX) && (bus.r_len != '0);

  // NOTE: always_comb assigns every output a default before the case so no
  // path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    flush_n   = 1'b0;
    err_n     = 1'b0;
    start_ok  = 1'b0;
    abort_hit = 1'b0;
`ifdef SW_ABORT_EN
    abort_hit = bus.abort && (state != S_IDLE);
`endif

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (legal) begin
            state_n  = S_LOAD_Q;
            cnt_n    = '0;
            flush_n  = 1'b1;
            start_ok = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_LOAD_Q: begin
        if (cnt == q_len_r - ONE) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_RUN: begin
        if (cnt == r_len_r - ONE) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      // q_len+1 drain cycles: count runs 0..q_len inclusive.
      S_DRAIN: begin
        if (cnt == q_len_r) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Abort overrides every transition, including leaving DONE.
    if (abort_hit) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      flush_n = 1'b1;
    end

    // Addresses follow the in-state counter and hold their last value elsewhere.
    q_addr_n = (state_n == S_LOAD_Q) ? cnt_n : q_addr_r;
    r_addr_n = (state_n == S_RUN)    ? cnt_n : r_addr_r;
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe without any combinational path to the ports.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      q_len_r     <= '0;
      r_len_r     <= '0;
      q_addr_r    <= '0;
      r_addr_r    <= '0;
      beat        <= '0;
      max_pos_r   <= '0;
      max_score_r <= '0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      q_load_r    <= 1'b0;
      r_rd_r      <= 1'b0;
      pe_en_r     <= 1'b0;
      pe_flush_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      q_addr_r   <= q_addr_n;
      r_addr_r   <= r_addr_n;
      busy_r     <= (state_n != S_IDLE);
      q_load_r   <= (state_n == S_LOAD_Q);
      r_rd_r     <= (state_n == S_RUN);
      pe_en_r    <= (state_n == S_RUN) || (state_n == S_DRAIN);
      done_r     <= (state_n == S_DONE);
      pe_flush_r <= flush_n;
      err_r      <= err_n;

      if (start_ok) begin
        q_len_r <= bus.q_len;
        r_len_r <= bus.r_len;
      end

      // Score tracker: strict compare keeps the earliest beat on ties; the
      // beat counter saturates so max_pos never wraps on long references.
      if (start_ok || abort_hit) begin
        beat        <= '0;
        max_pos_r   <= '0;
        max_score_r <= '0;
      end else if ((state != S_IDLE) && bus.pe_score_vld) begin
        if (beat != '1) beat <= beat + ONE;
        if (bus.pe_score > max_score_r) begin
          max_score_r <= bus.pe_score;
          max_pos_r   <= beat;
        end
      end
    end
  end

  assign bus.busy      = busy_r;
  assign bus.err       = err_r;
  assign bus.q_load    = q_load_r;
  assign bus.q_addr    = q_addr_r;
  assign bus.r_rd      = r_rd_r;
  assign bus.r_addr    = r_addr_r;
  assign bus.pe_en     = pe_en_r;
  assign bus.pe_flush  = pe_flush_r;
  assign bus.done      = done_r;
  assign bus.max_score = max_score_r;
  assign bus.max_pos   = max_pos_r;

endmodule

// File: tb/tb_sw_job_ctrl.sv
// tb_sw_job_ctrl -- scoreboard bench for sw_job_ctrl. Stimulus pushes the
// expected output events (with the cycle they must appear in) into a queue;
// a monitor on the falling edge turns DUT activity into events and pops and
// compares them in order. Cycle 0 is the cycle in which start is held high.
module tb_sw_job_ctrl;
  localparam int N_PE    = 16;
  localparam int LEN_W   = 10;
  localparam int SCORE_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sw_job_if #(.LEN_W(LEN_W), .SCORE_W(SCORE_W)) bus ();

  sw_job_ctrl #(.N_PE(N_PE), .LEN_W(LEN_W), .SCORE_W(SCORE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef enum int {EV_RST, EV_FLUSH, EV_QLD, EV_RRD, EV_PE_ON, EV_PE_OFF,
                    EV_BUSY_ON, EV_BUSY_OFF, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       a;
    int       b;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  int  sc[$];
  int  last_t0, last_end;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input ev_kind_t k, input int c, input int a, input int b);
    ev_t e;
    e.kind = k; e.cyc = c; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic obs(input ev_kind_t k, input int a, input int b);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_%s: got cyc=%0d a=%0d b=%0d, required no event",
               k.name(), cyc, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.a != a || e.b != b) begin
        n_bad++;
        $display("FAIL %s: got %s cyc=%0d a=%0d b=%0d, required %s cyc=%0d a=%0d b=%0d",
                 e.kind.name(), k.name(), cyc, a, b, e.kind.name(), e.cyc, e.a, e.b);
      end
    end
  endtask

  // Monitor: events within one cycle are reported in a fixed order that the
  // expectation generator reproduces.
  logic busy_q = 1'b0;
  logic pe_en_q = 1'b0;
  logic any_out;
  always @(negedge clk) begin
    any_out = |{bus.busy, bus.err, bus.q_load, bus.q_addr, bus.r_rd, bus.r_addr,
                bus.pe_en, bus.pe_flush, bus.done, bus.max_score, bus.max_pos};
    if (rst) begin
      obs(EV_RST, int'(any_out), 0);
      busy_q  <= 1'b0;
      pe_en_q <= 1'b0;
    end else begin
      if (bus.pe_flush) obs(EV_FLUSH, int'(bus.max_score), int'(bus.max_pos));
      if (bus.q_load)   obs(EV_QLD, int'(bus.q_addr), 0);
      if (bus.r_rd)     obs(EV_RRD, int'(bus.r_addr), 0);
      if (bus.pe_en && !pe_en_q) obs(EV_PE_ON, 0, 0);
      if (!bus.pe_en && pe_en_q) obs(EV_PE_OFF, 0, 0);
      if (bus.busy && !busy_q)   obs(EV_BUSY_ON, 0, 0);
      if (!bus.busy && busy_q)   obs(EV_BUSY_OFF, 0, 0);
      if (bus.done) obs(EV_DONE, int'(bus.max_score), int'(bus.max_pos));
      if (bus.err)  obs(EV_ERR, int'(bus.max_score), int'(bus.max_pos));
      busy_q  <= bus.busy;
      pe_en_q <= bus.pe_en;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected trace of a job accepted in cycle t0, up to (excluding) cycle cut.
  task automatic job_events(input int t0, input int ql, input int rl,
                            input int mx, input int mp, input int cut);
    int done_c;
    done_c = t0 + 2*ql + rl + 2;
    for (int c = t0 + 1; c <= done_c + 1; c++) begin
      if (c >= cut) break;
      if (c == t0 + 1) push(EV_FLUSH, c, 0, 0);
      if (c >= t0 + 1 && c <= t0 + ql) push(EV_QLD, c, c - t0 - 1, 0);
      if (c >= t0 + ql + 1 && c <= t0 + ql + rl) push(EV_RRD, c, c - t0 - ql - 1, 0);
      if (c == t0 + ql + 1) push(EV_PE_ON, c, 0, 0);
      if (c == done_c) push(EV_PE_OFF, c, 0, 0);
      if (c == t0 + 1) push(EV_BUSY_ON, c, 0, 0);
      if (c == done_c + 1) push(EV_BUSY_OFF, c, 0, 0);
      if (c == done_c) push(EV_DONE, c, mx, mp);
    end
  endtask

  task automatic start_job(input int ql, input int rl, input int mx, input int mp,
                           input int cut_rel);
    last_t0  = cyc;
    last_end = last_t0 + 2*ql + rl + 4;
    job_events(last_t0, ql, rl, mx, mp, last_t0 + cut_rel);
    bus.start = 1'b1;
    bus.q_len = LEN_W'(ql);
    bus.r_len = LEN_W'(rl);
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic finish_job();
    if (cyc < last_end) tick(last_end - cyc);
  endtask

  // One score beat per cycle from the shared sc queue.
  task automatic beats();
    foreach (sc[i]) begin
      bus.pe_score_vld = 1'b1;
      bus.pe_score     = SCORE_W'(sc[i]);
      tick(1);
    end
    bus.pe_score_vld = 1'b0;
    bus.pe_score     = '0;
  endtask

  task automatic bad_start(input int ql, input int rl, input int mx, input int mp);
    push(EV_ERR, cyc + 1, mx, mp);
    bus.start = 1'b1;
    bus.q_len = LEN_W'(ql);
    bus.r_len = LEN_W'(rl);
    tick(1);
    bus.start = 1'b0;
    tick(2);
  endtask

  localparam int NO_CUT = 1 << 30;

  initial begin
    bus.start        = 1'b0;
    bus.q_len        = '0;
    bus.r_len        = '0;
    bus.pe_score_vld = 1'b0;
    bus.pe_score     = '0;
`ifdef SW_ABORT_EN
    bus.abort        = 1'b0;
`endif

    // Reset state.
    @(posedge clk);
    #1;
    push(EV_RST, cyc, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick(2);

    // Nominal job with max tracking, plus an ignored start in cycle 6.
    start_job(4, 8, 9, 1, NO_CUT);
    sc = '{3, 9, 5, 9, 2};
    beats();
    bus.start = 1'b1;
    bus.q_len = LEN_W'(2);
    bus.r_len = LEN_W'(2);
    tick(1);
    bus.start = 1'b0;
    finish_job();

    // Score beat in IDLE is ignored; illegal lengths leave the tracker alone.
    bus.pe_score_vld = 1'b1;
    bus.pe_score     = SCORE_W'(500);
    tick(1);
    bus.pe_score_vld = 1'b0;
    bad_start(0, 8, 9, 1);
    bad_start(N_PE + 1, 8, 9, 1);
    bad_start(4, 0, 9, 1);

    // Boundary lengths; tie at the maximum keeps the earliest beat.
    start_job(N_PE, 1, 7, 0, NO_CUT);
    sc = '{7, 7, 4};
    beats();
    finish_job();
    start_job(1, 1, 0, 0, NO_CUT);
    finish_job();

    // Reset in RUN (cycle 8), then a fresh job sees only its own scores.
    start_job(4, 8, 0, 0, 8);
    sc = '{50};
    beats();
    tick(last_t0 + 8 - cyc);
    rst = 1'b1;
    push(EV_RST, cyc, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick(2);
    start_job(2, 3, 6, 1, NO_CUT);
    sc = '{4, 6};
    beats();
    finish_job();

    // Long reference: 1025 rising scores push the beat counter past saturation.
    sc.delete();
    for (int i = 1; i <= 1025; i++) sc.push_back(i);
    start_job(1, 1023, 1025, 1023, NO_CUT);
    beats();
    finish_job();

`ifdef SW_ABORT_EN
    // Abort in DRAIN (cycle 6): flush + idle next cycle, tracker cleared.
    start_job(2, 2, 0, 0, 7);
    sc = '{20};
    beats();
    tick(last_t0 + 6 - cyc);
    push(EV_FLUSH, last_t0 + 7, 0, 0);
    push(EV_PE_OFF, last_t0 + 7, 0, 0);
    push(EV_BUSY_OFF, last_t0 + 7, 0, 0);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    tick(2);
    start_job(1, 1, 0, 0, NO_CUT);
    finish_job();
`endif

    tick(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events: got %0d still pending, required 0 (next %s cyc=%0d)",
               exp_q.size(), exp_q[0].kind.name(), exp_q[0].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of stimulus, required finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
